// File: rtl/fight_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fight_pkg : shared FSM encoding, winner codes and default match tuning.
// Revision  : 1.0
// ---------------------------------------------------------------------------
package fight_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_COUNTDOWN = 3'd1,
    ST_FIGHT     = 3'd2,
    ST_KO        = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  localparam logic [9:0] DEF_REACH     = 10'd70;
  localparam logic [9:0] DEF_PUNCH_ACT = 10'd14;
  localparam int         DEF_FPS       = 60;
  localparam int         DEF_ROUND_SEC = 99;
  localparam int         DEF_COUNT_FR  = 180;
  localparam int         DEF_KO_FR     = 120;

  // Action codes 11..14 form one punch animation; outside it a player re-arms.
  localparam logic [9:0] ARM_LO = 10'd11;
  localparam logic [9:0] ARM_HI = 10'd14;

  // A knockout decides outright; otherwise (timeout) the higher health wins.
  function automatic logic [1:0] pick_winner(input logic [9:0] h1, input logic [9:0] h2);
    logic [1:0] w;
    if (h1 == 10'd0 && h2 == 10'd0) w = WIN_DRAW;
    else if (h2 == 10'd0)           w = WIN_P1;
    else if (h1 == 10'd0)           w = WIN_P2;
    else if (h1 > h2)               w = WIN_P1;
    else if (h2 > h1)               w = WIN_P2;
    else                            w = WIN_DRAW;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/strike_detect.sv
`default_nettype none
// ---------------------------------------------------------------------------
// strike_detect : one player's punch connects (striking frame, facing, in reach).
// Revision      : 1.0
// ---------------------------------------------------------------------------
module strike_detect
  import fight_pkg::*;
#(
  parameter logic [9:0] REACH     = DEF_REACH,
  parameter logic [9:0] PUNCH_ACT = DEF_PUNCH_ACT
) (
  input  logic [9:0] i_self_x,
  input  logic [9:0] i_opp_x,
  input  logic [9:0] i_self_act,
  input  logic       i_face_right,
  output logic       o_strike
);

  logic [9:0] w_dist;
  logic       w_facing;
  logic       w_in_reach;

  assign w_dist     = (i_self_x > i_opp_x) ? (i_self_x - i_opp_x) : (i_opp_x - i_self_x);
  assign w_facing   = i_face_right ? (i_opp_x > i_self_x) : (i_opp_x < i_self_x);
  assign w_in_reach = (w_dist <= REACH);
  assign o_strike   = (i_self_act == PUNCH_ACT) && w_facing && w_in_reach;

endmodule
`default_nettype wire

// File: rtl/match_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// match_ctrl : round sequencing, timer, hit arbitration and winner decision.
// Revision   : 1.0
// ---------------------------------------------------------------------------
module match_ctrl
  import fight_pkg::*;
#(
  parameter logic [9:0] REACH     = DEF_REACH,
  parameter logic [9:0] PUNCH_ACT = DEF_PUNCH_ACT,
  parameter int         FPS       = DEF_FPS,
  parameter int         ROUND_SEC = DEF_ROUND_SEC,
  parameter int         COUNT_FR  = DEF_COUNT_FR,
  parameter int         KO_FR     = DEF_KO_FR
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic       start,
  input  logic [9:0] p1x,
  input  logic [9:0] p2x,
  input  logic [9:0] action1,
  input  logic [9:0] action2,
  input  logic [9:0] direction1,
  input  logic [9:0] direction2,
  input  logic [9:0] health1,
  input  logic [9:0] health2,
  output logic       hit1,
  output logic       hit2,
  output logic       freeze,
  output logic       round_rst,
  output logic [6:0] timer_sec,
  output logic [1:0] winner,
  output logic [2:0] state
);

  localparam logic [15:0] c_CD_LAST   = 16'(COUNT_FR - 1);
  localparam logic [15:0] c_KO_LAST   = 16'(KO_FR - 1);
  localparam logic [15:0] c_FR_LAST   = 16'(FPS - 1);
  localparam logic [6:0]  c_ROUND_SEC = 7'(ROUND_SEC);

  logic [1:0]  r_fsync;
  logic        r_fprev;
  logic        r_start_d;
  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_cnt;
  logic [15:0] r_fr;
  logic [6:0]  r_timer;
  logic [1:0]  r_winner;
  logic        r_round_rst;
  logic        r_hit1, r_hit2;
  logic        r_armed1, r_armed2;

  logic w_frame_tick;
  logic w_start_rise;
  logic w_round_go;
  logic w_in_fight;
  logic w_fight_end;
  logic w_strike1, w_strike2;
  logic w_fire1, w_fire2;
  logic w_unused;

  // Only the facing bit of each direction word carries meaning.
  assign w_unused = &{1'b0, direction1[9:1], direction2[9:1]};

  assign w_frame_tick = r_fsync[1] & ~r_fprev;
  assign w_start_rise = start & ~r_start_d;
  assign w_in_fight   = (r_state == ST_FIGHT);
  assign w_fight_end  = w_in_fight && w_frame_tick &&
                        (health1 == 10'd0 || health2 == 10'd0 || r_timer == 7'd0);

  strike_detect #(.REACH(REACH), .PUNCH_ACT(PUNCH_ACT)) u_strike_p1 (
    .i_self_x     (p1x),
    .i_opp_x      (p2x),
    .i_self_act   (action1),
    .i_face_right (direction1[0]),
    .o_strike     (w_strike1)
  );

  strike_detect #(.REACH(REACH), .PUNCH_ACT(PUNCH_ACT)) u_strike_p2 (
    .i_self_x     (p2x),
    .i_opp_x      (p1x),
    .i_self_act   (action2),
    .i_face_right (direction2[0]),
    .o_strike     (w_strike2)
  );

  assign w_fire1 = w_in_fight && w_frame_tick && w_strike1 && r_armed1;
  assign w_fire2 = w_in_fight && w_frame_tick && w_strike2 && r_armed2;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_fsync   <= 2'b00;
      r_fprev   <= 1'b0;
      r_start_d <= 1'b0;
    end else begin
      r_fsync   <= {r_fsync[0], frame_clk};
      r_fprev   <= r_fsync[1];
      r_start_d <= start;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_round_go  = 1'b0;
    unique case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_start_rise) begin
          w_state_nxt = ST_COUNTDOWN;
          w_round_go  = 1'b1;
        end
      end
      ST_COUNTDOWN: if (w_frame_tick && r_cnt == c_CD_LAST) w_state_nxt = ST_FIGHT;
      ST_FIGHT:     if (w_fight_end) w_state_nxt = ST_KO;
      ST_KO:        if (w_frame_tick && r_cnt == c_KO_LAST) w_state_nxt = ST_DONE;
      default:      w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_round_rst <= 1'b0;
      r_timer     <= c_ROUND_SEC;
      r_winner    <= WIN_NONE;
      r_cnt       <= '0;
      r_fr        <= '0;
    end else begin
      r_round_rst <= w_round_go;
      if (w_round_go) begin
        r_timer  <= c_ROUND_SEC;
        r_winner <= WIN_NONE;
        r_cnt    <= '0;
        r_fr     <= '0;
      end else if (w_frame_tick) begin
        case (r_state)
          ST_COUNTDOWN, ST_KO: r_cnt <= (w_state_nxt != r_state) ? 16'd0 : r_cnt + 16'd1;
          ST_FIGHT: begin
            // The deciding frame freezes the clock so timer_sec shows where the round ended.
            if (w_fight_end) begin
              r_winner <= pick_winner(health1, health2);
              r_cnt    <= '0;
            end else if (r_fr == c_FR_LAST) begin
              r_fr <= '0;
              if (r_timer != 7'd0) r_timer <= r_timer - 7'd1;
            end else begin
              r_fr <= r_fr + 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_hit1   <= 1'b0;
      r_hit2   <= 1'b0;
      r_armed1 <= 1'b1;
      r_armed2 <= 1'b1;
    end else begin
      if (!w_in_fight) begin
        r_hit1 <= 1'b0;
        r_hit2 <= 1'b0;
      end else if (w_frame_tick) begin
        r_hit1 <= w_fire1;
        r_hit2 <= w_fire2;
      end
      if (w_fire1)                                    r_armed1 <= 1'b0;
      else if (action1 < ARM_LO || action1 > ARM_HI)  r_armed1 <= 1'b1;
      if (w_fire2)                                    r_armed2 <= 1'b0;
      else if (action2 < ARM_LO || action2 > ARM_HI)  r_armed2 <= 1'b1;
    end
  end

  // Hit registers can lag the FIGHT exit by one Clk; gate them on the live state.
  assign hit1      = r_hit1 & w_in_fight;
  assign hit2      = r_hit2 & w_in_fight;
  assign freeze    = ~w_in_fight;
  assign round_rst = r_round_rst;
  assign timer_sec = r_timer;
  assign winner    = r_winner;
  assign state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_match_ctrl.sv
`default_nettype none
// tb_match_ctrl: directed rounds against a frame-level reference model of the match rules.
module tb_match_ctrl;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       frame_clk = 1'b0;
  logic       start = 1'b0;
  logic [9:0] p1x, p2x, action1, action2, direction1, direction2, health1, health2;
  logic       hit1, hit2, freeze, round_rst;
  logic [6:0] timer_sec;
  logic [1:0] winner;
  logic [2:0] state;

  int n_vec = 0;
  int n_err = 0;

  match_ctrl dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .start(start),
    .p1x(p1x), .p2x(p2x), .action1(action1), .action2(action2),
    .direction1(direction1), .direction2(direction2),
    .health1(health1), .health2(health2),
    .hit1(hit1), .hit2(hit2), .freeze(freeze), .round_rst(round_rst),
    .timer_sec(timer_sec), .winner(winner), .state(state)
  );

  always #5 Clk = ~Clk;
  initial begin
    #7;
    forever #30 frame_clk = ~frame_clk;
  end

  // ---------------- reference model (phases: 0 idle,1 countdown,2 fight,3 ko,4 done)
  int m_ph = 0, m_timer = 99, m_win = 0, m_ticks = 0, m_sub = 0;
  bit m_h1 = 0, m_h2 = 0, m_a1 = 1, m_a2 = 1, m_rr = 0, m_start_d = 0;
  bit t_s1 = 0, t_s2 = 0, t_s3 = 0;
  bit m_tick, m_rise, m_f1, m_f2;

  function automatic bit strikes(input int sx, input int ox, input int act, input bit right);
    int d;
    d = (sx > ox) ? sx - ox : ox - sx;
    return (act == 14) && (right ? (ox > sx) : (ox < sx)) && (d <= 70);
  endfunction

  function automatic int judge(input int h1, input int h2);
    if (h1 == 0 && h2 == 0) return 3;
    if (h2 == 0) return 1;
    if (h1 == 0) return 2;
    if (h1 > h2) return 1;
    if (h2 > h1) return 2;
    return 3;
  endfunction

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      m_ph = 0; m_timer = 99; m_win = 0; m_ticks = 0; m_sub = 0;
      m_h1 = 0; m_h2 = 0; m_a1 = 1; m_a2 = 1; m_rr = 0; m_start_d = 0;
      t_s1 = 0; t_s2 = 0; t_s3 = 0;
    end else begin
      m_tick = t_s2 && !t_s3;
      m_rise = start && !m_start_d;
      t_s3 = t_s2; t_s2 = t_s1; t_s1 = frame_clk; m_start_d = start;
      m_rr = 0; m_f1 = 0; m_f2 = 0;
      case (m_ph)
        0, 4: if (m_rise) begin
          m_rr = 1; m_timer = 99; m_win = 0; m_ph = 1; m_ticks = 0; m_sub = 0;
        end
        1: if (m_tick) begin
          m_ticks++;
          if (m_ticks == 180) begin m_ph = 2; m_ticks = 0; end
        end
        2: if (m_tick) begin
          m_f1 = strikes(int'(p1x), int'(p2x), int'(action1), direction1[0]) && m_a1;
          m_f2 = strikes(int'(p2x), int'(p1x), int'(action2), direction2[0]) && m_a2;
          m_h1 = m_f1; m_h2 = m_f2;
          if (health1 == 0 || health2 == 0 || m_timer == 0) begin
            m_ph = 3; m_win = judge(int'(health1), int'(health2)); m_ticks = 0;
          end else begin
            m_sub++;
            if (m_sub == 60) begin m_sub = 0; if (m_timer > 0) m_timer--; end
          end
        end
        3: if (m_tick) begin
          m_ticks++;
          if (m_ticks == 120) m_ph = 4;
        end
        default: ;
      endcase
      if (m_f1) m_a1 = 0; else if (action1 < 11 || action1 > 14) m_a1 = 1;
      if (m_f2) m_a2 = 0; else if (action2 < 11 || action2 > 14) m_a2 = 1;
      if (m_ph != 2) begin m_h1 = 0; m_h2 = 0; end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare and pulse counters
  int cnt_h1 = 0, cnt_h2 = 0, cnt_both = 0, cnt_rr = 0;
  logic [15:0] exp_v, got_v;
  always @(negedge Clk) begin
    exp_v = {3'(m_ph), (m_ph != 2), m_rr, 7'(m_timer), 2'(m_win), m_h1, m_h2};
    got_v = {state, freeze, round_rst, timer_sec, winner, hit1, hit2};
    check("outputs{state,freeze,rr,timer,winner,hit1,hit2}", 32'(got_v), 32'(exp_v));
    cnt_h1   += int'(hit1);
    cnt_h2   += int'(hit2);
    cnt_both += int'(hit1 & hit2);
    cnt_rr   += int'(round_rst);
  end

  // ---------------- stimulus helpers
  task automatic step();
    @(posedge Clk);
    #2;
  endtask

  task automatic next_frame();
    int n;
    n = 0;
    @(negedge Clk);
    while (!(t_s2 && !t_s3) && n < 20) begin
      @(negedge Clk);
      n++;
    end
    if (n >= 20) begin
      n_vec++; n_err++;
      $display("FAIL frame_wait: no frame tick within 20 cycles");
    end
    @(posedge Clk);
    #2;
  endtask

  task automatic wait_state(input logic [2:0] s, input int limit, input string name);
    int n;
    n = 0;
    while (state !== s && n < limit) begin
      step();
      n++;
    end
    if (state !== s) begin
      n_vec++; n_err++;
      $display("FAIL %s: state %0d never reached, still %0d", name, s, state);
    end
  endtask

  task automatic punch_seq1(input int a0, input int a1, input int a2, input int a3, input int a4);
    int seq[5];
    seq = '{a0, a1, a2, a3, a4};
    for (int i = 0; i < 5; i++) begin
      next_frame();
      action1 = 10'(seq[i]);
    end
    next_frame();
    next_frame();
  endtask

  int h0, b0, r0, g0;

  initial begin
    p1x = 10'd200; p2x = 10'd260; action1 = 10'd0; action2 = 10'd0;
    direction1 = 10'd1; direction2 = 10'd0; health1 = 10'd100; health2 = 10'd100;
    repeat (4) @(posedge Clk);
    #2 Reset_n = 1'b1;
    @(negedge Clk); #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_freeze", 32'(freeze), 32'd1);
    check("rst_timer", 32'(timer_sec), 32'd99);
    check("rst_winner", 32'(winner), 32'd0);
    check("rst_hits", 32'({hit1, hit2, round_rst}), 32'd0);

    step();
    r0 = cnt_rr;
    start = 1'b1;
    repeat (8) step();
    check("round_rst_pulses", 32'(cnt_rr - r0), 32'd1);
    check("countdown_state", 32'(state), 32'd1);
    wait_state(3'd2, 1200, "enter_fight");
    check("fight_freeze", 32'(freeze), 32'd0);
    check("fight_timer", 32'(timer_sec), 32'd99);

    h0 = cnt_h1;
    punch_seq1(12, 13, 14, 14, 11);
    check("punch_one_frame_cycles", 32'(cnt_h1 - h0), 32'd6);

    p2x = 10'd280;
    h0 = cnt_h1;
    punch_seq1(11, 14, 14, 11, 0);
    check("out_of_reach_80", 32'(cnt_h1 - h0), 32'd0);

    p2x = 10'd260; direction1 = 10'd0;
    h0 = cnt_h1;
    punch_seq1(11, 14, 11, 0, 0);
    check("facing_away", 32'(cnt_h1 - h0), 32'd0);
    direction1 = 10'd1;

    p2x = 10'd250;
    h0 = cnt_h2; b0 = cnt_both;
    next_frame(); action1 = 10'd11; action2 = 10'd11;
    next_frame(); action1 = 10'd14; action2 = 10'd14;
    next_frame(); action1 = 10'd11; action2 = 10'd11;
    next_frame(); next_frame();
    check("trade_both_cycles", 32'(cnt_both - b0), 32'd6);
    check("trade_hit2_cycles", 32'(cnt_h2 - h0), 32'd6);

    next_frame();
    health2 = 10'd0;
    wait_state(3'd3, 20, "ko_entry");
    check("ko_winner", 32'(winner), 32'd1);
    check("ko_freeze", 32'(freeze), 32'd1);
    wait_state(3'd4, 800, "done_entry");
    check("done_winner", 32'(winner), 32'd1);
    repeat (3) next_frame();
    check("start_held_no_retrigger", 32'(state), 32'd4);

    start = 1'b0; health1 = 10'd40; health2 = 10'd40;
    action1 = 10'd0; action2 = 10'd0;
    step();
    start = 1'b1;
    wait_state(3'd2, 1200, "fight_round2");
    wait_state(3'd3, 37000, "timeout_ko");
    check("timeout_draw_winner", 32'(winner), 32'd3);
    check("timeout_timer", 32'(timer_sec), 32'd0);
    wait_state(3'd4, 800, "done_round2");

    start = 1'b0;
    step();
    start = 1'b1;
    wait_state(3'd2, 1200, "fight_round3");
    start = 1'b0;
    repeat (5) next_frame();
    Reset_n = 1'b0;
    #1;
    check("midfight_rst_state", 32'(state), 32'd0);
    check("midfight_rst_outs", 32'({freeze, round_rst, hit1, hit2, winner}), 32'b100000);
    check("midfight_rst_timer", 32'(timer_sec), 32'd99);
    step();
    Reset_n = 1'b1;
    g0 = cnt_rr;
    repeat (5) next_frame();
    check("idle_without_start_edge", 32'(state), 32'd0);
    check("no_round_rst_after_reset", 32'(cnt_rr - g0), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
